alu_muldiv: RTL



---
 rtl/alu_muldiv_pkg.sv | 34 +++
 rtl/md_signfix.sv | 48 ++++
 rtl/alu_muldiv.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: MD op codes, FSM state type and op-class helpers
// shared by the multiply/divide unit and its sign-fix helper.
`timescale 1ns/1ps
package alu_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MFHI  = 3'd4;
  localparam logic [2:0] MD_MFLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_sgn(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_signfix.sv
// md_signfix: operand magnitude/sign extraction and final sign correction.
// Ports: is_signed/a/b -> a_mag/b_mag/a_neg/b_neg; is_div/neg_q/neg_r with
// raw_hi/raw_lo (unsigned result) -> fix_hi/fix_lo (signed-corrected result).
`timescale 1ns/1ps
module md_signfix #(
  parameter int WIDTH = 32
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_mag,
  output logic [WIDTH-1:0] b_mag,
  output logic             a_neg,
  output logic             b_neg,
  input  logic             is_div,
  input  logic             neg_q,
  input  logic             neg_r,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] raw_p;
  logic [2*WIDTH-1:0] neg_p;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Product is negated as one 2W-bit value; quotient and
  // remainder are corrected independently.
  always_comb begin
    raw_p = {raw_hi, raw_lo};
    neg_p = -raw_p;
    if (is_div) begin
      fix_lo = neg_q ? -raw_lo : raw_lo;
      fix_hi = neg_r ? -raw_hi : raw_hi;
    end else begin
      fix_hi = neg_q ? neg_p[2*WIDTH-1:WIDTH] : raw_hi;
      fix_lo = neg_q ? neg_p[WIDTH-1:0] : raw_lo;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MFxx/MTxx.
// Ports: clk, rst (sync, active-high), start/op/A/B issue; busy/done/stall
// status; hi/lo registers; result = (op==MFHI) ? hi : lo.
// Option macro MD_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
`timescale 1ns/1ps
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e state;
  md_state_e state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  // acc: product high half / partial remainder
  // shr: multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] opnd;
  logic             div_q;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             iter_go;
  logic             fast_go;
  logic             last;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] shr_nxt;

  logic             fix_div;
  logic             fix_nq;
  logic             fix_nr;
  logic [WIDTH-1:0] raw_hi;
  logic [WIDTH-1:0] raw_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign stall   = start && busy;
  assign accept  = start && !busy;
  assign last    = (cnt == LAST);
  assign iter_go = accept && is_md(op) && !fast_go;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign result  = (op == MD_MFHI) ? hi_q : lo_q;

  md_signfix #(
    .WIDTH(WIDTH)
  ) u_fix (
    .is_signed(is_sgn(op)),
    .a        (A),
    .b        (B),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .a_neg    (a_neg),
    .b_neg    (b_neg),
    .is_div   (fix_div),
    .neg_q    (fix_nq),
    .neg_r    (fix_nr),
    .raw_hi   (raw_hi),
    .raw_lo   (raw_lo),
    .fix_hi   (fix_hi),
    .fix_lo   (fix_lo)
  );

  // One radix-2 step. Restoring divide: the borrow bit of
  // diff decides between subtract and restore.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, opnd};
    shl  = {acc, shr[WIDTH-1]};
    diff = shl - {1'b0, opnd};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        shr_nxt = {shr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shl[WIDTH-1:0];
        shr_nxt = {shr[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (shr[0]) begin
        {acc_nxt, shr_nxt} = {sum, shr[WIDTH-1:1]};
      end else begin
        {acc_nxt, shr_nxt} = {1'b0, acc, shr[WIDTH-1:1]};
      end
    end
  end

`ifdef MD_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_p;

  assign fast_go = accept && is_md(op) && !is_div_op(op);
  assign fast_p  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fix_div = fast_go ? 1'b0 : div_q;
  assign fix_nq  = fast_go ? (a_neg ^ b_neg) : neg_q;
  assign fix_nr  = neg_r;
  assign {raw_hi, raw_lo} = fast_go ? fast_p : {acc_nxt, shr_nxt};
`else
  assign fast_go = 1'b0;
  assign fix_div = div_q;
  assign fix_nq  = neg_q;
  assign fix_nr  = neg_r;
  assign {raw_hi, raw_lo} = {acc_nxt, shr_nxt};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        if (fast_go) begin
          state_nxt = ST_DONE;
        end else if (iter_go) begin
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      acc   <= '0;
      shr   <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (1'b1)
        fast_go: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        iter_go: begin
          cnt   <= '0;
          acc   <= '0;
          div_q <= is_div_op(op);
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          shr   <= is_div_op(op) ? a_mag : b_mag;
          opnd  <= is_div_op(op) ? b_mag : a_mag;
        end
        (accept && op == MD_MTHI): begin
          hi_q <= A;
        end
        (accept && op == MD_MTLO): begin
          lo_q <= A;
        end
        busy: begin
          acc <= acc_nxt;
          shr <= shr_nxt;
          cnt <= last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
